bf_in_sel_ctrl: RTL
===================

// Module: bf_in_sel_ctrl
// PURPOSE
//  Stage/cycle sequencer for the 8-bank -> 4xBFU input crossbar (network_bf_in) in the radix-4 4x2BFU NTT core.
//  - Walks STAGE_NUM stages of 2^CYC_LOG read cycles each.
//  - Per read cycle it issues the bank read address and eight conflict-free 3-bit bank->BFU-port selects.
//  - Inserts a PIPE_LAT drain gap after every stage.
//  - Start/done handshake to the top-level NTT controller.
// PARAMETERS
//  STAGE_NUM  4  number of NTT stages per transform (>=1)
//  STG_W      2  width of the stage index, >= clog2(STAGE_NUM)
//  CYC_LOG    5  log2 of read cycles per stage (>=3); 256 coeffs / 8 banks = 32
//  PIPE_LAT   6  drain-gap cycles after each stage (>=1); BFU + write-back latency
// PORTS
//  clk      in   1           clock, all state on posedge
//  rst      in   1           synchronous, active-high reset
//  start    in   1           begin transform; sampled only in IDLE
//  stall    in   1           freeze RUN progress this cycle
//  busy     out  1           high from first RUN cycle through last GAP cycle
//  done     out  1           one-cycle pulse after last GAP cycle
//  stage    out  STG_W       current stage index
//  rd_en    out  1           bank read strobe
//  rd_addr  out  CYC_LOG     bank read address (= cycle counter)
//  sel_a    out  24          packed selects; sel_a[3k+2:3k] drives sel_a_k of the crossbar
//  sel_vld  out  1           rd_en delayed 1 clk; crossbar u/v outputs valid
// BEHAVIOUR
//  Reset:
//   - state=IDLE; busy=0, done=0, rd_en=0, sel_vld=0, stage=0, rd_addr=0.
//   - sel_a=24'hFAC688 (identity, sel_a_k=k). sel_a also holds this value in IDLE and GAP.
//   - rst mid-transform: IDLE on the next edge, no done pulse.
//  FSM states: IDLE, RUN, GAP.
//  IDLE:
//   - start=1 -> RUN with stage=0, cyc=0.
//   - start is ignored in every other state.
//  RUN:
//   - rd_en = !stall; rd_addr = cyc.
//   - perm = rotl3(cyc[2:0], stage mod 3).
//   - sel_a_k = k ^ perm. This is a bijection, so no two q inputs ever hit the same u/v port.
//   - cyc increments only when !stall.
//   - cyc == 2^CYC_LOG-1 && !stall -> GAP with gcnt=0. cyc wraps to 0.
//  GAP:
//   - rd_en=0; stall has no effect; gcnt increments every cycle.
//   - gcnt == PIPE_LAT-1 and stage == last -> IDLE, done=1 for one cycle.
//   - gcnt == PIPE_LAT-1 otherwise -> stage+1, RUN.
//  Output timing:
//   - rd_en/rd_addr/sel_a are decoded from registered state. Only stall->rd_en is combinational.
//   - The crossbar registers sel internally, so sel_a is issued in the same cycle as rd_en.
//   - sel_vld is rd_en registered once.
//  Latency:
//   - start sampled at edge T. RUN starts at T+1.
//   - busy is high for STAGE_NUM*(2^CYC_LOG+PIPE_LAT) cycles plus total stall cycles.
//   - done is high in the following cycle, with busy=0. Defaults with no stall: done at T+153.
//  Simultaneous events:
//   - start during the done cycle is accepted (state is already IDLE).
//   - rst wins over start.
// CONFIGURATION
//  STAGE_REVERSE_EN defined:
//   - Adds input port `inv` (1 bit), captured when start is accepted.
//   - inv=1: stage runs STAGE_NUM-1 down to 0 and done follows stage 0. perm uses the actual stage value.
//   - inv=0: identical to the undefined build.
//  STAGE_REVERSE_EN undefined:
//   - No inv port. Stages always ascend from 0.
// TESTING
//  1 Reset: rst=1 for 2 clk -> busy=0, done=0, rd_en=0, sel_vld=0, sel_a=24'hFAC688.
//  2 Full run, defaults, no stall: one start pulse ->
//    - 4x(32 rd_en cycles with rd_addr 0..31, then 6 idle cycles);
//    - done pulse exactly 153 clk after start; sel_vld = rd_en delayed 1.
//  3 Select check, stage=1, cyc=5 -> perm=3, sel_a_0=3, sel_a_7=4.
//    Every RUN cycle: all eight sel_a_k distinct.
//  4 Stall in stage 0 at cyc=10, held 3 clk -> rd_en=0 and rd_addr=10 held during stall; done at 156.
//  5 rst at stage 2 -> IDLE next clk, no done.
//    start while busy -> ignored, total length unchanged.
//  6 STAGE_REVERSE_EN, inv=1 -> stage sequence 3,2,1,0; at stage 3, cyc=6, sel_a_0=6; done after stage 0.

Source files
------------

// File: rtl/bf_in_sel_ctrl.sv
// Stage/cycle sequencer for the 8-bank -> 4xBFU input crossbar of the radix-4 NTT core.
// Optional STAGE_REVERSE_EN adds an `inv` input that walks the stages in descending order.
module bf_in_sel_ctrl #(
    parameter int unsigned STAGE_NUM = 4,
    parameter int unsigned STG_W     = 2,
    parameter int unsigned CYC_LOG   = 5,
    parameter int unsigned PIPE_LAT  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stall,
`ifdef STAGE_REVERSE_EN
    input  logic               inv,
`endif
    output logic               busy,
    output logic               done,
    output logic [STG_W-1:0]   stage,
    output logic               rd_en,
    output logic [CYC_LOG-1:0] rd_addr,
    output logic [23:0]        sel_a,
    output logic               sel_vld
);

    localparam int unsigned GW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

    state_t             r_state;
    logic [STG_W-1:0]   r_stage;
    logic [CYC_LOG-1:0] r_cyc;
    logic [GW-1:0]      r_gcnt;
    logic               r_busy;
    logic               r_done;
    logic               r_sel_vld;

    logic [STG_W-1:0]   w_first_stage;
    logic [STG_W-1:0]   w_last_stage;
    logic [STG_W-1:0]   w_next_stage;
    logic [1:0]         w_rot;
    logic [2:0]         w_perm;
    logic [23:0]        w_sel;

`ifdef STAGE_REVERSE_EN
    logic r_inv;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inv <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_inv <= inv;
        end
    end

    // First stage uses the live inv; later decisions use the captured copy.
    assign w_first_stage = inv   ? STG_W'(STAGE_NUM - 1) : '0;
    assign w_last_stage  = r_inv ? '0 : STG_W'(STAGE_NUM - 1);
    assign w_next_stage  = r_inv ? r_stage - 1'b1 : r_stage + 1'b1;
`else
    assign w_first_stage = '0;
    assign w_last_stage  = STG_W'(STAGE_NUM - 1);
    assign w_next_stage  = r_stage + 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_stage <= '0;
            r_cyc   <= '0;
            r_gcnt  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_stage <= w_first_stage;
                        r_cyc   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        r_cyc <= r_cyc + 1'b1;
                        if (r_cyc == '1) begin
                            r_state <= GAP;
                            r_gcnt  <= '0;
                        end
                    end
                end
                GAP: begin
                    r_gcnt <= r_gcnt + 1'b1;
                    if (r_gcnt == GW'(PIPE_LAT - 1)) begin
                        if (r_stage == w_last_stage) begin
                            r_state <= IDLE;
                            r_stage <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_stage <= w_next_stage;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_vld <= 1'b0;
        end else begin
            r_sel_vld <= rd_en;
        end
    end

    function automatic logic [2:0] rotl3(input logic [2:0] v, input logic [1:0] n);
        case (n)
            2'd1:    return {v[1:0], v[2]};
            2'd2:    return {v[0], v[2:1]};
            default: return v;
        endcase
    endfunction

    // XOR with a per-cycle constant is a bijection on 0..7, so the eight selects never collide.
    always_comb begin
        w_rot  = 2'(r_stage % 3);
        w_perm = (r_state == RUN) ? rotl3(r_cyc[2:0], w_rot) : 3'd0;
        w_sel  = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            w_sel[3*k +: 3] = 3'(k) ^ w_perm;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign stage   = r_stage;
    assign rd_en   = (r_state == RUN) && !stall;
    assign rd_addr = r_cyc;
    assign sel_a   = w_sel;
    assign sel_vld = r_sel_vld;

endmodule
